// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write-back, read and issue/scoreboard signals of the register file
interface register_file_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic                     i_write_back;
   logic [ADDR_W-1:0]        i_write_addr;
   logic [DATA_W-1:0]        i_write_data;
   logic [ADDR_W-1:0]        i_read_addr1;
   logic [ADDR_W-1:0]        i_read_addr2;
   logic [DATA_W-1:0]        o_read_data1;
   logic [DATA_W-1:0]        o_read_data2;
   logic                     i_src1_used;
   logic                     i_src2_used;
   logic                     i_issue_valid;
   logic                     i_issue_writes;
   logic [ADDR_W-1:0]        i_issue_dest;
   logic                     i_flush;
   logic                     o_stall;
   logic [(1<<ADDR_W)-1:0]   o_pending;

   modport slave (
      input  i_write_back, i_write_addr, i_write_data,
      input  i_read_addr1, i_read_addr2,
      input  i_src1_used, i_src2_used,
      input  i_issue_valid, i_issue_writes, i_issue_dest, i_flush,
      output o_read_data1, o_read_data2, o_stall, o_pending
   );

   modport master (
      output i_write_back, i_write_addr, i_write_data,
      output i_read_addr1, i_read_addr2,
      output i_src1_used, i_src2_used,
      output i_issue_valid, i_issue_writes, i_issue_dest, i_flush,
      input  o_read_data1, o_read_data2, o_stall, o_pending
   );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - register array with pending-write scoreboard and RAW stall
// REGFILE_BYPASS_EN enables write-through reads and same-cycle stall release.
module register_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 2
) (
   input logic            i_clk,
   input logic            i_reset,
   register_file_if.slave bus
);
   localparam int NREG = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs [NREG];
   logic [CNT_W-1:0]  cnt  [NREG];

   logic retiring1, retiring2;
   logic hazard1, hazard2, dest_full, issue_accept;

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      bus.o_read_data1 = regs[bus.i_read_addr1];
      bus.o_read_data2 = regs[bus.i_read_addr2];
      if (bus.i_write_back && (bus.i_write_addr == bus.i_read_addr1))
         bus.o_read_data1 = bus.i_write_data;
      if (bus.i_write_back && (bus.i_write_addr == bus.i_read_addr2))
         bus.o_read_data2 = bus.i_write_data;
   end

   // The final outstanding write to a source frees the stall in its own cycle.
   assign retiring1 = bus.i_write_back && (bus.i_write_addr == bus.i_read_addr1)
                      && (cnt[bus.i_read_addr1] == CNT_ONE);
   assign retiring2 = bus.i_write_back && (bus.i_write_addr == bus.i_read_addr2)
                      && (cnt[bus.i_read_addr2] == CNT_ONE);
`else
   always_comb begin
      bus.o_read_data1 = regs[bus.i_read_addr1];
      bus.o_read_data2 = regs[bus.i_read_addr2];
   end

   assign retiring1 = 1'b0;
   assign retiring2 = 1'b0;
`endif

   assign hazard1 = bus.i_src1_used && (cnt[bus.i_read_addr1] != '0) && !retiring1;
   assign hazard2 = bus.i_src2_used && (cnt[bus.i_read_addr2] != '0) && !retiring2;

   // Saturation guard: a full counter must never take another increment.
   assign dest_full = bus.i_issue_valid && bus.i_issue_writes
                      && (cnt[bus.i_issue_dest] == CNT_MAX);

   assign bus.o_stall   = hazard1 || hazard2 || dest_full;
   assign issue_accept  = bus.i_issue_valid && bus.i_issue_writes && !bus.o_stall;

   always_comb begin
      bus.o_pending = '0;
      for (int i = 0; i < NREG; i++)
         bus.o_pending[i] = (cnt[i] != '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
            cnt[i]  <= '0;
         end
      end else begin
         if (bus.i_write_back)
            regs[bus.i_write_addr] <= bus.i_write_data;
         for (int i = 0; i < NREG; i++) begin
            if (bus.i_flush) begin
               cnt[i] <= '0;
            end else begin
               // Matching increment and decrement on the same edge cancel out.
               if ((issue_accept && (bus.i_issue_dest == ADDR_W'(i)))
                   && !(bus.i_write_back && (bus.i_write_addr == ADDR_W'(i)) && (cnt[i] != '0)))
                  cnt[i] <= cnt[i] + CNT_ONE;
               else if (!(issue_accept && (bus.i_issue_dest == ADDR_W'(i)))
                        && (bus.i_write_back && (bus.i_write_addr == ADDR_W'(i)) && (cnt[i] != '0)))
                  cnt[i] <= cnt[i] - CNT_ONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 2;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_underflow observed=%h expected=none", obs);
      end else begin
         check(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   task automatic drive_idle();
      bus.i_write_back   = 1'b0;
      bus.i_write_addr   = '0;
      bus.i_write_data   = '0;
      bus.i_read_addr1   = '0;
      bus.i_read_addr2   = '0;
      bus.i_src1_used    = 1'b0;
      bus.i_src2_used    = 1'b0;
      bus.i_issue_valid  = 1'b0;
      bus.i_issue_writes = 1'b0;
      bus.i_issue_dest   = '0;
      bus.i_flush        = 1'b0;
   endtask

   task automatic issue(input logic [ADDR_W-1:0] dest);
      bus.i_issue_valid  = 1'b1;
      bus.i_issue_writes = 1'b1;
      bus.i_issue_dest   = dest;
   endtask

   task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.i_write_back = 1'b1;
      bus.i_write_addr = a;
      bus.i_write_data = d;
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      drive_idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Load R3, then reset with a write and an issue on the same edge
      write(3'd3, 16'h1234);
      tick();
      drive_idle();
      bus.i_read_addr1 = 3'd3;
      expect_val("r3_loaded", 32'h1234);
      settle();
      pop_check({16'h0, bus.o_read_data1});
      rst = 1'b1;
      write(3'd3, 16'hFFFF);
      issue(3'd5);
      tick();
      rst = 1'b0;
      drive_idle();

      for (int i = 0; i < 8; i++) begin
         bus.i_read_addr1 = ADDR_W'(i);
         bus.i_read_addr2 = ADDR_W'(7 - i);
         expect_val($sformatf("reset_rd1_r%0d", i), 32'h0);
         expect_val($sformatf("reset_rd2_r%0d", 7 - i), 32'h0);
         expect_val("reset_pending", 32'h0);
         expect_val("reset_stall", 32'h0);
         settle();
         pop_check({16'h0, bus.o_read_data1});
         pop_check({16'h0, bus.o_read_data2});
         pop_check({24'h0, bus.o_pending});
         pop_check({31'h0, bus.o_stall});
         tick();
      end

      // Write R5 and read it in the same cycle and the next
      write(3'd5, 16'hBEEF);
      bus.i_read_addr1 = 3'd5;
      bus.i_read_addr2 = 3'd5;
      expect_val("r5_same_cycle", BYP ? 32'hBEEF : 32'h0);
      settle();
      pop_check({16'h0, bus.o_read_data1});
      tick();
      drive_idle();
      bus.i_read_addr1 = 3'd5;
      bus.i_read_addr2 = 3'd5;
      expect_val("r5_rd1", 32'hBEEF);
      expect_val("r5_rd2", 32'hBEEF);
      settle();
      pop_check({16'h0, bus.o_read_data1});
      pop_check({16'h0, bus.o_read_data2});
      tick();

      // RAW hazard on R2
      drive_idle();
      issue(3'd2);
      expect_val("raw_issue_stall", 32'h0);
      settle();
      pop_check({31'h0, bus.o_stall});
      tick();
      drive_idle();
      bus.i_src1_used  = 1'b1;
      bus.i_read_addr1 = 3'd2;
      expect_val("raw_stall", 32'h1);
      expect_val("raw_pending", 32'h04);
      settle();
      pop_check({31'h0, bus.o_stall});
      pop_check({24'h0, bus.o_pending});
      tick();
      write(3'd2, 16'h0042);
      expect_val("raw_wb_stall", BYP ? 32'h0 : 32'h1);
      expect_val("raw_wb_rd1", BYP ? 32'h0042 : 32'h0);
      settle();
      pop_check({31'h0, bus.o_stall});
      pop_check({16'h0, bus.o_read_data1});
      tick();
      drive_idle();
      bus.i_src1_used  = 1'b1;
      bus.i_read_addr1 = 3'd2;
      expect_val("raw_after_stall", 32'h0);
      expect_val("raw_after_rd1", 32'h0042);
      expect_val("raw_after_pending", 32'h0);
      settle();
      pop_check({31'h0, bus.o_stall});
      pop_check({16'h0, bus.o_read_data1});
      pop_check({24'h0, bus.o_pending});
      tick();

      // Three in-flight writes to R1 fill the counter
      for (int k = 0; k < 3; k++) begin
         drive_idle();
         issue(3'd1);
         expect_val($sformatf("multi_issue%0d_stall", k), 32'h0);
         settle();
         pop_check({31'h0, bus.o_stall});
         tick();
      end
      drive_idle();
      issue(3'd1);
      expect_val("multi_full_stall", 32'h1);
      expect_val("multi_full_pending", 32'h02);
      settle();
      pop_check({31'h0, bus.o_stall});
      pop_check({24'h0, bus.o_pending});
      tick();
      drive_idle();
      write(3'd1, 16'h0011);
      tick();
      drive_idle();
      issue(3'd1);
      write(3'd1, 16'h0022);
      expect_val("multi_simul_stall", 32'h0);
      settle();
      pop_check({31'h0, bus.o_stall});
      tick();
      drive_idle();
      issue(3'd1);
      expect_val("multi_refill_stall", 32'h0);
      settle();
      pop_check({31'h0, bus.o_stall});
      tick();
      drive_idle();
      issue(3'd1);
      expect_val("multi_refull_stall", 32'h1);
      settle();
      pop_check({31'h0, bus.o_stall});
      tick();

      // Flush wins over a concurrent issue
      drive_idle();
      issue(3'd4);
      tick();
      issue(3'd6);
      tick();
      issue(3'd7);
      bus.i_flush = 1'b1;
      expect_val("flush_pre_pending", 32'h52);
      expect_val("flush_pre_stall", 32'h0);
      settle();
      pop_check({24'h0, bus.o_pending});
      pop_check({31'h0, bus.o_stall});
      tick();
      drive_idle();
      expect_val("flush_pending", 32'h0);
      settle();
      pop_check({24'h0, bus.o_pending});
      tick();

      // Stray write to a register with no pending count
      write(3'd0, 16'h00A5);
      expect_val("stray_pre_pending", 32'h0);
      settle();
      pop_check({24'h0, bus.o_pending});
      tick();
      drive_idle();
      expect_val("stray_rd1", 32'h00A5);
      expect_val("stray_pending", 32'h0);
      settle();
      pop_check({16'h0, bus.o_read_data1});
      pop_check({24'h0, bus.o_pending});
      tick();

      // Mid-operation reset discards pending state
      issue(3'd3);
      tick();
      drive_idle();
      expect_val("midrst_pre_pending", 32'h08);
      settle();
      pop_check({24'h0, bus.o_pending});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_read_addr1 = 3'd5;
      expect_val("midrst_pending", 32'h0);
      expect_val("midrst_rd1", 32'h0);
      settle();
      pop_check({24'h0, bus.o_pending});
      pop_check({16'h0, bus.o_read_data1});
      tick();

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
